// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag vector width and flag bit indices.
package cpu_pkg;

  localparam int unsigned FLAGS_W = 4;

  // Bit positions inside the stored {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_logic_if.sv
// Bundle between instruction decode/ALU and the conditional-execution unit.
//   master: decoder/ALU side (drives cond, ALU flags, write requests)
//   slave : cond_logic side (drives gated writes, cond_ex, stored flags)
interface cond_logic_if;

  logic [3:0]                  cond;
  logic                        alu_n;
  logic                        alu_z;
  logic                        alu_co;
  logic                        alu_ovf;
  logic [1:0]                  flag_w;
  logic                        pcs;
  logic                        reg_w;
  logic                        mem_w;
  logic                        no_write;
  logic                        pc_src;
  logic                        reg_write;
  logic                        mem_write;
  logic                        cond_ex;
  logic [cpu_pkg::FLAGS_W-1:0] flags;

  modport master (
    output cond, alu_n, alu_z, alu_co, alu_ovf, flag_w, pcs, reg_w, mem_w, no_write,
    input  pc_src, reg_write, mem_write, cond_ex, flags
  );

  modport slave (
    input  cond, alu_n, alu_z, alu_co, alu_ovf, flag_w, pcs, reg_w, mem_w, no_write,
    output pc_src, reg_write, mem_write, cond_ex, flags
  );

endinterface

// File: rtl/cond_logic_cond_check.sv
// Combinational condition-field decoder.
//   cond    : instruction condition field
//   flags   : stored {N,Z,C,V}
//   cond_ex : 1 when the condition passes
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0]         cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
  end

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = ~ge;
      COND_GT: cond_ex = ~z & ge;
      COND_LE: cond_ex = z | ~ge;
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the {N,Z,C,V} flags, evaluates the
// instruction condition against them and gates PC/register/memory writes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cond_logic_if.slave (decoder/ALU inputs, gated outputs, flags)
module cond_logic
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cond_logic_if.slave   bus
);

  logic [FLAGS_W-1:0] flags_q;
  logic [FLAGS_W-1:0] flags_d;
  logic               cond_ex_c;

  // Condition is evaluated against the stored (pre-edge) flags only
  cond_check u_cond_check (
    .cond    (bus.cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_c)
  );

  // N/Z and C/V groups update independently, and only when the condition passes
  always_comb begin
    flags_d = flags_q;
    if (bus.flag_w[1] && cond_ex_c) begin
      flags_d[FLAG_N] = bus.alu_n;
      flags_d[FLAG_Z] = bus.alu_z;
    end
    if (bus.flag_w[0] && cond_ex_c) begin
      flags_d[FLAG_C] = bus.alu_co;
      flags_d[FLAG_V] = bus.alu_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.cond_ex   = cond_ex_c;
  assign bus.pc_src    = bus.pcs & cond_ex_c;
  assign bus.mem_write = bus.mem_w & cond_ex_c;
  assign bus.reg_write = bus.reg_w & cond_ex_c & ~bus.no_write;
  assign bus.flags     = flags_q;

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter: FLAGS_W, 4, width of stored flag vector {N,Z,C,V}; fixed at 4, not overridable.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: cond  input  4  instruction condition field [31:28].
REQ-005 SHALL have port: alu_n, alu_z, alu_co, alu_ovf  input  1 each  current-cycle ALU flag outputs N, Z, CO, OVF.
REQ-006 SHALL have port: flag_w  input  2  flag write request; bit1 = N/Z group, bit0 = C/V group.
REQ-007 SHALL have port: pcs  input  1  decoder request to write PC.
REQ-008 SHALL have port: reg_w  input  1  decoder request to write register file.
REQ-009 SHALL have port: mem_w  input  1  decoder request to write data memory.
REQ-010 SHALL have port: no_write  input  1  compare-type instruction; suppresses register write.
REQ-011 SHALL have port: pc_src  output  1  gated PC write.
REQ-012 SHALL have port: reg_write  output  1  gated register write.
REQ-013 SHALL have port: mem_write  output  1  gated memory write.
REQ-014 SHALL have port: cond_ex  output  1  condition-pass indication.
REQ-015 SHALL have port: flags  output  4  stored flags {N,Z,C,V}, direct from register.

Function
REQ-016 SHALL hold flags in a 4-bit register; only state element.
REQ-017 SHALL compute cond_ex combinationally from cond and stored flags (not ALU inputs), same cycle.
REQ-018 SHALL decode cond: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
REQ-019 SHALL decode cond: 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1.
REQ-020 SHALL drive pc_src = pcs & cond_ex; mem_write = mem_w & cond_ex; reg_write = reg_w & cond_ex & ~no_write.
REQ-021 SHALL on rising edge, when flag_w[1] & cond_ex, load N<=alu_n, Z<=alu_z; otherwise hold N,Z.
REQ-022 SHALL on rising edge, when flag_w[0] & cond_ex, load C<=alu_co, V<=alu_ovf; otherwise hold C,V.
REQ-023 SHALL update the two groups independently; flag_w=10 with logic ALU op leaves C,V unchanged.
REQ-024 SHALL, when cond fails, suppress all flag updates and all three write outputs that cycle.
REQ-025 SHALL use pre-edge flags for cond_ex in a cycle that also updates flags; new flags affect only following cycle.
REQ-026 SHALL treat all inputs as unregistered; outputs other than flags are combinational, zero latency.

Reset
REQ-027 SHALL on rst=1 clear flags to 0000 immediately, independent of clk.
REQ-028 SHALL with flags=0000 and cond=EQ give cond_ex=0; AL gives cond_ex=1 during reset.
REQ-029 SHALL ignore flag_w while rst=1; first update on first rising edge after rst deasserts.
REQ-030 SHALL, on reset mid-operation, discard any pending update; no partial group write.

Structure
REQ-031 SHALL place cond code constants (EQ..AL, NV) and flag bit indices (N=3, Z=2, C=1, V=0) in shared package cpu_pkg.
REQ-032 SHALL implement cond decode as sub-module cond_check (combinational: cond, flags -> cond_ex); register and gating in cond_logic.

Verification
REQ-033 SHALL verify: rst pulse mid-cycle with flags=1111 -> flags=0000 before next edge; cond=0000 gives cond_ex=0.
REQ-034 SHALL verify: cond=1110, flag_w=11, alu {N,Z,CO,OVF}=0110 -> after edge flags=0110; next cycle cond=0000 gives cond_ex=1, cond=0010 gives cond_ex=1.
REQ-035 SHALL verify: flags=0100, cond=0001 (NE), flag_w=11, pcs=1, reg_w=1, mem_w=1 -> cond_ex=0, pc_src=reg_write=mem_write=0, flags stay 0100.
REQ-036 SHALL verify: flags=0011, cond=AL, flag_w=10, alu=1000 -> flags=1011 (C,V held).
REQ-037 SHALL verify: flags=1001, cond=1100 (GT) -> cond_ex=1; flags=1000 -> GT 0, LT 1, LE 1; cond=AL, reg_w=1, no_write=1 -> reg_write=0.
REQ-038 SHALL verify: exhaustive 16 cond x 16 flag combinations against reference table of REQ-018/019.
